param_updn_counter: RTL and testbench

- Parametrised successor to the 16-bit load/up/down counter: configurable width and step, programmable lower/upper limits, selectable wrap/saturate/one-shot limit handling.
- Adds registered terminal-count pulse, sticky overflow/underflow flags, configuration-error detection and a halt state.
- Drop-in replacement for the existing counter in the system bench; legacy port names kept, new ports added.

---
 rtl/updn_pkg.sv | 20 ++
 rtl/updn_next_calc.sv | 61 ++++++
 rtl/param_updn_counter.sv | 109 ++++++++++
 tb/tb_param_updn_counter.sv | 269 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/updn_pkg.sv
// Shared types for the parametrised up/down counter.
// Latency: n/a (types only).
// Backpressure: n/a.
package updn_pkg;

  // Limit handling selected by the mode input; reserved behaves as wrap.
  typedef enum logic [1:0] {
    MODE_WRAP    = 2'b00,
    MODE_SAT     = 2'b01,
    MODE_ONESHOT = 2'b10,
    MODE_RSVD    = 2'b11
  } mode_t;

  // RUN counts normally; HALT freezes the count after a one-shot crossing.
  typedef enum logic {
    ST_RUN  = 1'b0,
    ST_HALT = 1'b1
  } state_t;

endpackage

// File: rtl/updn_next_calc.sv
// Next-count arithmetic: candidate value, limit crossing detection, mode-dependent landing value.
// Latency: purely combinational.
// Backpressure: none; the result is valid for whatever inputs are presented.
module updn_next_calc
  import updn_pkg::*;
#(
  parameter int WIDTH  = 16,
  parameter int STEP_W = 4
) (
  input  logic [WIDTH-1:0]  cnt_i,
  input  logic [STEP_W-1:0] step_i,
  input  logic              up_i,
  input  logic [WIDTH-1:0]  lo_lim_i,
  input  logic [WIDTH-1:0]  hi_lim_i,
  input  mode_t             mode_i,
  output logic [WIDTH-1:0]  nxt_o,
  output logic              cross_o,
  output logic              cross_up_o,
  output logic              cross_dn_o
);

  // One extra bit of headroom so neither the up sum nor the down floor can wrap.
  logic [WIDTH:0]   cnt_x;
  logic [WIDTH:0]   step_x;
  logic [WIDTH:0]   lo_x;
  logic [WIDTH:0]   hi_x;
  logic [WIDTH:0]   up_sum;
  logic [WIDTH:0]   dn_floor;
  logic [WIDTH-1:0] dn_diff;

  assign cnt_x    = {1'b0, cnt_i};
  assign step_x   = {{(WIDTH + 1 - STEP_W){1'b0}}, step_i};
  assign lo_x     = {1'b0, lo_lim_i};
  assign hi_x     = {1'b0, hi_lim_i};
  assign up_sum   = cnt_x + step_x;
  assign dn_floor = lo_x + step_x;
  // Only used when no down-crossing, i.e. cnt >= lo + step >= step, so it never underflows.
  assign dn_diff  = cnt_i - step_x[WIDTH-1:0];

  // Landing exactly on a limit is not a crossing, hence strict comparisons.
  assign cross_up_o = up_i & (up_sum > hi_x);
  assign cross_dn_o = ~up_i & (cnt_x < dn_floor);
  assign cross_o    = cross_up_o | cross_dn_o;

  // Pick the landing value: plain candidate, opposite limit (wrap) or crossed limit (sat/one-shot).
  always_comb begin
    nxt_o = up_i ? up_sum[WIDTH-1:0] : dn_diff;
    if (cross_up_o) begin
      case (mode_i)
        MODE_SAT, MODE_ONESHOT: nxt_o = hi_lim_i;
        default:                nxt_o = lo_lim_i;
      endcase
    end else if (cross_dn_o) begin
      case (mode_i)
        MODE_SAT, MODE_ONESHOT: nxt_o = lo_lim_i;
        default:                nxt_o = hi_lim_i;
      endcase
    end
  end

endmodule

// File: rtl/param_updn_counter.sv
// Parametrised load/up/down counter with programmable limits, wrap/saturate/one-shot handling and sticky flags.
// Latency: load and count results appear on data_out one cycle after the sampling edge; tc is registered.
// Backpressure: none; every input is sampled each cycle, cfg_err and HALT simply freeze counting.
module param_updn_counter
  import updn_pkg::*;
#(
  parameter int WIDTH  = 16,
  parameter int STEP_W = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [WIDTH-1:0]  data_in,
  input  logic              ld_cnt,
  input  logic              updn_cnt,
  input  logic              count_enb,
  input  logic [STEP_W-1:0] step,
  input  logic [1:0]        mode,
  input  logic [WIDTH-1:0]  lo_lim,
  input  logic [WIDTH-1:0]  hi_lim,
  input  logic              clr_flags,
  output logic [WIDTH-1:0]  data_out,
  output logic              tc,
  output logic              ovf,
  output logic              unf,
  output logic              halted,
  output logic              cfg_err
);

  logic [WIDTH-1:0] cnt_q, cnt_d;
  logic             tc_q, tc_d;
  logic             ovf_q, ovf_d;
  logic             unf_q, unf_d;
  state_t           state_q, state_d;

  mode_t            mode_e;
  logic [WIDTH-1:0] calc_nxt;
  logic             calc_cross;
  logic             calc_cross_up;
  logic             calc_cross_dn;
  logic             do_step;

  assign mode_e  = mode_t'(mode);
  assign cfg_err = (lo_lim > hi_lim);

  // A zero step is treated as "no step" so it can never produce a crossing or tc.
  assign do_step = count_enb & ~ld_cnt & (state_q == ST_RUN) & ~cfg_err & (step != '0);

  updn_next_calc #(
    .WIDTH  (WIDTH),
    .STEP_W (STEP_W)
  ) u_next_calc (
    .cnt_i      (cnt_q),
    .step_i     (step),
    .up_i       (updn_cnt),
    .lo_lim_i   (lo_lim),
    .hi_lim_i   (hi_lim),
    .mode_i     (mode_e),
    .nxt_o      (calc_nxt),
    .cross_o    (calc_cross),
    .cross_up_o (calc_cross_up),
    .cross_dn_o (calc_cross_dn)
  );

  // Next-state for count, FSM, terminal-count pulse and sticky flags (load beats counting).
  always_comb begin
    cnt_d   = cnt_q;
    state_d = state_q;
    tc_d    = 1'b0;
    if (ld_cnt) begin
      cnt_d   = data_in;
      state_d = ST_RUN;
    end else if (do_step) begin
      cnt_d = calc_nxt;
      if (calc_cross) begin
        tc_d = 1'b1;
        if (mode_e == MODE_ONESHOT) begin
          state_d = ST_HALT;
        end
      end
    end
    // A new crossing in the same cycle as a clear leaves the flag set.
    ovf_d = (ovf_q & ~clr_flags) | (do_step & calc_cross_up);
    unf_d = (unf_q & ~clr_flags) | (do_step & calc_cross_dn);
  end

  // State registers with synchronous reset taking priority over everything.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q   <= '0;
      tc_q    <= 1'b0;
      ovf_q   <= 1'b0;
      unf_q   <= 1'b0;
      state_q <= ST_RUN;
    end else begin
      cnt_q   <= cnt_d;
      tc_q    <= tc_d;
      ovf_q   <= ovf_d;
      unf_q   <= unf_d;
      state_q <= state_d;
    end
  end

  assign data_out = cnt_q;
  assign tc       = tc_q;
  assign ovf      = ovf_q;
  assign unf      = unf_q;
  assign halted   = (state_q == ST_HALT);

endmodule

// File: tb/tb_param_updn_counter.sv
// Self-checking bench for param_updn_counter: hand-derived vector table, corner sequences, random vs model.
// Latency: checks one cycle after each sampling edge.
// Backpressure: n/a.
module tb_param_updn_counter;

  localparam int W  = 16;
  localparam int SW = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic [W-1:0]  data_in;
  logic          ld_cnt;
  logic          updn_cnt;
  logic          count_enb;
  logic [SW-1:0] step;
  logic [1:0]    mode;
  logic [W-1:0]  lo_lim;
  logic [W-1:0]  hi_lim;
  logic          clr_flags;
  logic [W-1:0]  data_out;
  logic          tc;
  logic          ovf;
  logic          unf;
  logic          halted;
  logic          cfg_err;

  always #5 clk = ~clk;

  param_updn_counter #(.WIDTH(W), .STEP_W(SW)) dut (
    .clk       (clk),
    .rst       (rst),
    .data_in   (data_in),
    .ld_cnt    (ld_cnt),
    .updn_cnt  (updn_cnt),
    .count_enb (count_enb),
    .step      (step),
    .mode      (mode),
    .lo_lim    (lo_lim),
    .hi_lim    (hi_lim),
    .clr_flags (clr_flags),
    .data_out  (data_out),
    .tc        (tc),
    .ovf       (ovf),
    .unf       (unf),
    .halted    (halted),
    .cfg_err   (cfg_err)
  );

  int n_pass  = 0;
  int n_total = 0;

  // Reference model state: plain integers, evaluated from the behavioural rules.
  int m_cnt  = 0;
  bit m_tc   = 0;
  bit m_ovf  = 0;
  bit m_unf  = 0;
  bit m_halt = 0;

  typedef struct {
    logic         rst;
    logic         ld;
    logic [W-1:0] data;
    logic         en;
    logic         up;
    logic [SW-1:0] step;
    logic [1:0]   mode;
    logic [W-1:0] lo;
    logic [W-1:0] hi;
    logic         clr;
    int           e_cnt;
    int           e_tc;
    int           e_ovf;
    int           e_unf;
    int           e_halt;
    int           e_cfg;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(input logic r, input logic l, input int d, input logic e,
                              input logic u, input int s, input int md, input int lo,
                              input int hi, input logic c, input int ec, input int et,
                              input int eo, input int eu, input int eh, input int ecfg);
    vec_t v;
    v.rst = r; v.ld = l; v.data = W'(d); v.en = e; v.up = u; v.step = SW'(s);
    v.mode = 2'(md); v.lo = W'(lo); v.hi = W'(hi); v.clr = c;
    v.e_cnt = ec; v.e_tc = et; v.e_ovf = eo; v.e_unf = eu; v.e_halt = eh; v.e_cfg = ecfg;
    return v;
  endfunction

  task automatic check(input string name, input int act, input int exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
  endtask

  task automatic drive(input logic r, input logic l, input int d, input logic e, input logic u,
                       input int s, input int md, input int lo, input int hi, input logic c);
    rst = r; ld_cnt = l; data_in = W'(d); count_enb = e; updn_cnt = u;
    step = SW'(s); mode = 2'(md); lo_lim = W'(lo); hi_lim = W'(hi); clr_flags = c;
  endtask

  // Advance the model by one clock using the inputs currently applied.
  function automatic void model_step();
    int c, s, lo, hi, t;
    bit set_o, set_u, sat;
    set_o = 0; set_u = 0;
    c = m_cnt; s = int'(step); lo = int'(lo_lim); hi = int'(hi_lim);
    sat = (mode == 2'd1) || (mode == 2'd2);
    if (rst) begin
      m_cnt = 0; m_tc = 0; m_ovf = 0; m_unf = 0; m_halt = 0;
      return;
    end
    m_tc = 0;
    if (ld_cnt) begin
      m_cnt  = int'(data_in);
      m_halt = 0;
    end else if (count_enb && !m_halt && lo <= hi && s != 0) begin
      if (updn_cnt) begin
        t = c + s;
        if (t > hi) begin set_o = 1; m_cnt = sat ? hi : lo; end
        else m_cnt = t;
      end else begin
        t = c - s;
        if (t < lo) begin set_u = 1; m_cnt = sat ? lo : hi; end
        else m_cnt = t;
      end
      if (set_o || set_u) begin
        m_tc = 1;
        if (mode == 2'd2) m_halt = 1;
      end
    end
    m_ovf = (m_ovf && !clr_flags) || set_o;
    m_unf = (m_unf && !clr_flags) || set_u;
  endfunction

  task automatic tick();
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_model(input string tag);
    check({tag, " data_out"}, int'(data_out), m_cnt);
    check({tag, " tc"},       int'(tc),       int'(m_tc));
    check({tag, " ovf"},      int'(ovf),      int'(m_ovf));
    check({tag, " unf"},      int'(unf),      int'(m_unf));
    check({tag, " halted"},   int'(halted),   int'(m_halt));
    check({tag, " cfg_err"},  int'(cfg_err),  int'(lo_lim > hi_lim));
  endtask

  initial begin
    drive(1, 0, 0, 0, 1, 0, 0, 0, 10, 0);

    //            rst ld data  en up st md lo  hi     clr  cnt   tc ovf unf hlt cfg
    tbl.push_back(mk(1, 0, 0,     0, 1, 0, 0, 0,  10,    0,  0,    0, 0, 0, 0, 0));
    tbl.push_back(mk(1, 0, 0,     1, 1, 3, 0, 0,  10,    0,  0,    0, 0, 0, 0, 0));
    tbl.push_back(mk(0, 1, 'hF0,  0, 1, 0, 0, 0,  'hFFFF,0,  'hF0, 0, 0, 0, 0, 0));
    // wrap up, step 3
    tbl.push_back(mk(0, 1, 8,     0, 1, 3, 0, 0,  10,    0,  8,    0, 0, 0, 0, 0));
    tbl.push_back(mk(0, 0, 0,     1, 1, 3, 0, 0,  10,    0,  0,    1, 1, 0, 0, 0));
    tbl.push_back(mk(0, 0, 0,     0, 1, 3, 0, 0,  10,    0,  0,    0, 1, 0, 0, 0));
    tbl.push_back(mk(0, 1, 7,     0, 1, 3, 0, 0,  10,    0,  7,    0, 1, 0, 0, 0));
    tbl.push_back(mk(0, 0, 0,     1, 1, 3, 0, 0,  10,    0,  10,   0, 1, 0, 0, 0));
    tbl.push_back(mk(0, 0, 0,     0, 1, 3, 0, 0,  10,    1,  10,   0, 0, 0, 0, 0));
    // saturate down, step 4
    tbl.push_back(mk(0, 1, 7,     0, 0, 4, 1, 5,  100,   0,  7,    0, 0, 0, 0, 0));
    tbl.push_back(mk(0, 0, 0,     1, 0, 4, 1, 5,  100,   0,  5,    1, 0, 1, 0, 0));
    tbl.push_back(mk(0, 0, 0,     1, 0, 4, 1, 5,  100,   0,  5,    1, 0, 1, 0, 0));
    tbl.push_back(mk(0, 0, 0,     0, 0, 4, 1, 5,  100,   0,  5,    0, 0, 1, 0, 0));
    // one-shot up, step 1: landing on hi is not a crossing, the next step is
    tbl.push_back(mk(0, 1, 2,     0, 1, 1, 2, 0,  3,     1,  2,    0, 0, 0, 0, 0));
    tbl.push_back(mk(0, 0, 0,     1, 1, 1, 2, 0,  3,     0,  3,    0, 0, 0, 0, 0));
    tbl.push_back(mk(0, 0, 0,     1, 1, 1, 2, 0,  3,     0,  3,    1, 1, 0, 1, 0));
    tbl.push_back(mk(0, 1, 0,     0, 1, 1, 2, 0,  3,     0,  0,    0, 1, 0, 0, 0));
    tbl.push_back(mk(0, 0, 0,     1, 1, 1, 2, 0,  3,     0,  1,    0, 1, 0, 0, 0));
    // priority: load beats count; set beats clear; wrap down; reset mid-count
    tbl.push_back(mk(0, 1, 9,     1, 1, 1, 0, 0,  3,     0,  9,    0, 1, 0, 0, 0));
    tbl.push_back(mk(0, 0, 0,     1, 1, 1, 0, 0,  3,     1,  0,    1, 1, 0, 0, 0));
    tbl.push_back(mk(0, 0, 0,     1, 0, 2, 0, 0,  3,     0,  3,    1, 1, 1, 0, 0));
    tbl.push_back(mk(1, 0, 0,     1, 0, 2, 0, 0,  3,     0,  0,    0, 0, 0, 0, 0));
    // configuration error freezes counting but not loading
    tbl.push_back(mk(0, 1, 12,    0, 1, 1, 0, 20, 10,    0,  12,   0, 0, 0, 0, 1));
    tbl.push_back(mk(0, 0, 0,     1, 1, 1, 0, 20, 10,    0,  12,   0, 0, 0, 0, 1));
    tbl.push_back(mk(0, 1, 5,     0, 1, 1, 0, 20, 10,    0,  5,    0, 0, 0, 0, 1));
    tbl.push_back(mk(0, 0, 0,     1, 1, 0, 0, 0,  100,   0,  5,    0, 0, 0, 0, 0));
    tbl.push_back(mk(0, 0, 0,     1, 1, 2, 0, 0,  100,   0,  7,    0, 0, 0, 0, 0));
    // loaded above hi: up step crosses; reserved mode wraps; no modular wrap at top of range
    tbl.push_back(mk(0, 1, 200,   0, 1, 1, 1, 0,  100,   0,  200,  0, 0, 0, 0, 0));
    tbl.push_back(mk(0, 0, 0,     1, 1, 1, 1, 0,  100,   0,  100,  1, 1, 0, 0, 0));
    tbl.push_back(mk(0, 0, 0,     1, 0, 1, 3, 0,  100,   0,  99,   0, 1, 0, 0, 0));
    tbl.push_back(mk(0, 1, 'hFFFE,0, 1, 15,0, 0,  'hFFFF,0,  'hFFFE,0, 1, 0, 0, 0));
    tbl.push_back(mk(0, 0, 0,     1, 1, 15,0, 0,  'hFFFF,0,  0,    1, 1, 0, 0, 0));

    foreach (tbl[i]) begin
      drive(tbl[i].rst, tbl[i].ld, int'(tbl[i].data), tbl[i].en, tbl[i].up, int'(tbl[i].step),
            int'(tbl[i].mode), int'(tbl[i].lo), int'(tbl[i].hi), tbl[i].clr);
      tick();
      check($sformatf("vec%0d data_out", i), int'(data_out), tbl[i].e_cnt);
      check($sformatf("vec%0d tc", i),       int'(tc),       tbl[i].e_tc);
      check($sformatf("vec%0d ovf", i),      int'(ovf),      tbl[i].e_ovf);
      check($sformatf("vec%0d unf", i),      int'(unf),      tbl[i].e_unf);
      check($sformatf("vec%0d halted", i),   int'(halted),   tbl[i].e_halt);
      check($sformatf("vec%0d cfg_err", i),  int'(cfg_err),  tbl[i].e_cfg);
    end

    // One-shot halt holds through 5 enabled cycles and mode changes; only a load releases it.
    drive(0, 1, 2, 0, 1, 1, 2, 0, 3, 1);
    tick();
    drive(0, 0, 0, 1, 1, 1, 2, 0, 3, 0);
    tick();
    tick();
    check("oneshot halted", int'(halted), 1);
    check("oneshot tc", int'(tc), 1);
    for (int k = 0; k < 5; k++) begin
      drive(0, 0, 0, 1, k[0], 1, k % 4, 0, 3, 0);
      tick();
      check($sformatf("halt hold%0d data_out", k), int'(data_out), 3);
      check($sformatf("halt hold%0d halted", k),   int'(halted),   1);
      check($sformatf("halt hold%0d tc", k),       int'(tc),       0);
    end
    drive(0, 1, 0, 1, 1, 1, 2, 0, 3, 0);
    tick();
    check("halt release halted", int'(halted), 0);
    check("halt release data_out", int'(data_out), 0);
    drive(0, 0, 0, 1, 1, 1, 2, 0, 3, 0);
    tick();
    check("resume data_out", int'(data_out), 1);

    // Reset in the middle of counting clears everything on the next cycle.
    drive(0, 1, 0, 0, 1, 5, 0, 0, 100, 0);
    tick();
    drive(0, 0, 0, 1, 1, 5, 0, 0, 100, 0);
    repeat (3) tick();
    check("midcount data_out", int'(data_out), 15);
    drive(1, 1, 77, 1, 1, 5, 0, 0, 100, 0);
    tick();
    check("midrst data_out", int'(data_out), 0);
    check("midrst tc", int'(tc), 0);
    check("midrst halted", int'(halted), 0);
    drive(0, 0, 0, 1, 1, 5, 0, 0, 100, 0);
    tick();
    check("after rst data_out", int'(data_out), 5);

    // Randomised traffic against the reference model.
    for (int n = 0; n < 600; n++) begin
      int lo, hi, d;
      if ($urandom_range(0, 9) == 0) begin
        lo = int'($urandom_range(16'hFFE0, 16'hFFF0));
        hi = 'hFFFF;
        d  = int'($urandom_range(16'hFFD0, 16'hFFFF));
      end else begin
        lo = int'($urandom_range(0, 30));
        hi = int'($urandom_range(0, 60));
        d  = int'($urandom_range(0, 70));
      end
      drive($urandom_range(0, 49) == 0, $urandom_range(0, 9) == 0, d,
            $urandom_range(0, 9) < 7, $urandom_range(0, 1) == 1,
            int'($urandom_range(0, 15)), int'($urandom_range(0, 3)),
            lo, hi, $urandom_range(0, 9) == 0);
      tick();
      check_model($sformatf("rnd%0d", n));
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
